// File: rtl/ahb_apb_bridge_if.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge_if
// Bundles the AHB-Lite slave side and the APB master side of the bridge.
//
// Signal groups:
//   AHB request  : haddr_i, hsize_i, hprot_i, hnonsec_i, htrans_i, hwrite_i,
//                  hwdata_i, hwstrb_i, hsel_i, hready_i
//   AHB response : hrdata_o, hreadyout_o, hresp_o
//   APB request  : paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o,
//                  pstrb_o
//   APB response : prdata_i, pready_i, pslverr_i
//
// Modports:
//   slave  - the bridge's view (AHB slave that is also an APB requester)
//   master - the environment's view (AHB manager plus APB completer)
// The _i/_o suffixes are relative to the bridge.
// ---------------------------------------------------------------------------
interface ahb_apb_bridge_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int HPROT_WIDTH = 4
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // AHB side
  logic [ADDR_WIDTH-1:0]  haddr_i;
  logic [2:0]             hsize_i;
  logic [HPROT_WIDTH-1:0] hprot_i;
  logic                   hnonsec_i;
  logic [1:0]             htrans_i;
  logic                   hwrite_i;
  logic [DATA_WIDTH-1:0]  hwdata_i;
  logic [STRB_WIDTH-1:0]  hwstrb_i;
  logic                   hsel_i;
  logic                   hready_i;
  logic [DATA_WIDTH-1:0]  hrdata_o;
  logic                   hreadyout_o;
  logic                   hresp_o;

  // APB side
  logic [ADDR_WIDTH-1:0]  paddr_o;
  logic [2:0]             pprot_o;
  logic                   psel_o;
  logic                   penable_o;
  logic                   pwrite_o;
  logic [DATA_WIDTH-1:0]  pwdata_o;
  logic [STRB_WIDTH-1:0]  pstrb_o;
  logic [DATA_WIDTH-1:0]  prdata_i;
  logic                   pready_i;
  logic                   pslverr_i;

  modport slave (
    input  haddr_i, hsize_i, hprot_i, hnonsec_i, htrans_i, hwrite_i,
           hwdata_i, hwstrb_i, hsel_i, hready_i,
           prdata_i, pready_i, pslverr_i,
    output hrdata_o, hreadyout_o, hresp_o,
           paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
  );

  modport master (
    output haddr_i, hsize_i, hprot_i, hnonsec_i, htrans_i, hwrite_i,
           hwdata_i, hwstrb_i, hsel_i, hready_i,
           prdata_i, pready_i, pslverr_i,
    input  hrdata_o, hreadyout_o, hresp_o,
           paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
  );
endinterface

// File: rtl/ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge
// AHB-Lite slave to APB3/APB4 master bridge. Every accepted AHB transfer is
// turned into exactly one APB SETUP/ACCESS sequence while the AHB data phase
// is stalled through hreadyout_o. PSLVERR, oversize transfers and an
// optional ACCESS timeout are reported with the two-cycle AHB ERROR response.
//
// Ports:
//   hclk_i  - clock, everything on the rising edge
//   hrst_i  - synchronous active-high reset
//   bus     - ahb_apb_bridge_if.slave carrying the AHB request/response and
//             the APB request/response signals
//
// Parameters:
//   ADDR_WIDTH, DATA_WIDTH (8/16/32/64), HPROT_WIDTH (>=2),
//   TIMEOUT_CYCLES - ACCESS cycles allowed without pready_i; 0 disables
// ---------------------------------------------------------------------------
module ahb_apb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int HPROT_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              hclk_i,
  input  logic              hrst_i,
  ahb_apb_bridge_if.slave   bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  // Largest legal HSIZE encoding is log2 of the byte lanes.
  localparam int SIZE_MAX   = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    SETUP,
    ACCESS,
    RESP,
    ERR1,
    ERR2
  } state_e;

  state_e state_q, state_d;

  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  hreadyout_q, hreadyout_d;
  logic                  hresp_q, hresp_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [2:0]            pprot_q, pprot_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

  logic accept;
  logic can_accept;
  logic take;
  logic size_bad;
  logic timeout_hit;
  logic unused_inputs;

  // Only NONSEQ/SEQ count as a transfer; IDLE and BUSY fall through to an
  // OKAY zero-wait response simply by not being taken.
  assign accept     = bus.hsel_i & bus.hready_i & bus.htrans_i[1];
  assign can_accept = (state_q == IDLE) || (state_q == RESP) || (state_q == ERR2);
  assign take       = accept & can_accept;
  assign size_bad   = bus.hsize_i > 3'(SIZE_MAX);

  // Only two HPROT bits and the upper HTRANS bit carry meaning here.
  assign unused_inputs = ^{bus.hprot_i, bus.htrans_i[0]};

  // ACCESS timeout: the counter holds the number of ACCESS cycles already
  // spent waiting, so the TIMEOUT_CYCLES-th waiting cycle is the last one.
  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
      tmo_cnt_d = '0;
      if (state_q == ACCESS && !bus.pready_i) begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end

    always_ff @(posedge hclk_i) begin
      if (hrst_i) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_d;
      end
    end

    assign timeout_hit = (state_q == ACCESS) && !bus.pready_i &&
                         (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  // State and output registers. Every bus-visible output comes straight
  // from a flop so nothing combinational reaches either bus.
  always_ff @(posedge hclk_i) begin
    if (hrst_i) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pprot_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pprot_q     <= pprot_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      hrdata_q    <= hrdata_d;
    end
  end

  // Next-state logic. A transfer taken in RESP or ERR2 chains straight into
  // its first cycle so back-to-back transfers add no idle APB cycles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, RESP, ERR2: begin
        if (accept) begin
          if (size_bad) begin
            state_d = ERR1;
          end else if (bus.hwrite_i) begin
            state_d = WDATA;
          end else begin
            state_d = SETUP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WDATA:  state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        // A real response wins over a timeout landing in the same cycle.
        if (bus.pready_i) begin
          state_d = bus.pslverr_i ? ERR1 : RESP;
        end else if (timeout_hit) begin
          state_d = ERR1;
        end
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic. Control outputs are decoded from the next
  // state so they line up with the state register. The request fields only
  // change on a taken transfer or in WDATA, which keeps them stable from
  // SETUP through the last ACCESS cycle.
  always_comb begin
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    hreadyout_d = (state_d == IDLE) || (state_d == RESP) || (state_d == ERR2);
    hresp_d     = (state_d == ERR1) || (state_d == ERR2);

    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pprot_d  = pprot_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    hrdata_d = hrdata_q;

    if (take) begin
      paddr_d  = bus.haddr_i;
      pwrite_d = bus.hwrite_i;
      // APB PPROT = {instruction, non-secure, privileged}.
      pprot_d  = {~bus.hprot_i[0], bus.hnonsec_i, bus.hprot_i[1]};
      if (!bus.hwrite_i) begin
        pstrb_d = '0;
      end
    end

    // HWDATA/HWSTRB are valid in the AHB data phase, one cycle after the
    // address phase, which is exactly the WDATA state.
    if (state_q == WDATA) begin
      pwdata_d = bus.hwdata_i;
      pstrb_d  = bus.hwstrb_i;
    end

    // hrdata_o keeps its last value unless a read completes cleanly.
    if (state_q == ACCESS && bus.pready_i && !bus.pslverr_i && !pwrite_q) begin
      hrdata_d = bus.prdata_i;
    end
  end

  assign bus.psel_o      = psel_q;
  assign bus.penable_o   = penable_q;
  assign bus.hreadyout_o = hreadyout_q;
  assign bus.hresp_o     = hresp_q;
  assign bus.pwrite_o    = pwrite_q;
  assign bus.paddr_o     = paddr_q;
  assign bus.pprot_o     = pprot_q;
  assign bus.pwdata_o    = pwdata_q;
  assign bus.pstrb_o     = pstrb_q;
  assign bus.hrdata_o    = hrdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_ahb_apb_bridge
// Directed bench for ahb_apb_bridge (DATA_WIDTH=32, TIMEOUT_CYCLES=4).
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge, half a cycle after the rising edge that updated them.
// ctrl packs {psel_o, penable_o, hreadyout_o, hresp_o}.
// ---------------------------------------------------------------------------
module tb_ahb_apb_bridge;

  logic hclk;
  logic hrst;
  int   n_checks;
  int   n_errors;

  ahb_apb_bridge_if #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .HPROT_WIDTH(4)
  ) bus ();

  ahb_apb_bridge #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .HPROT_WIDTH   (4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .hclk_i(hclk),
    .hrst_i(hrst),
    .bus   (bus.slave)
  );

  logic [3:0] ctrl;
  assign ctrl = {bus.psel_o, bus.penable_o, bus.hreadyout_o, bus.hresp_o};

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Presents one AHB address phase.
  task automatic apply_stimulus(input logic [31:0] addr, input logic write,
                                input logic [2:0] size);
    bus.hsel_i   = 1'b1;
    bus.hready_i = 1'b1;
    bus.htrans_i = 2'b10;
    bus.haddr_i  = addr;
    bus.hwrite_i = write;
    bus.hsize_i  = size;
  endtask

  task automatic bus_idle();
    bus.hsel_i   = 1'b0;
    bus.htrans_i = 2'b00;
  endtask

  task automatic test_reset();
    hrst = 1'b1;
    repeat (2) @(negedge hclk);
    n_checks++; if (ctrl !== 4'b0010) begin n_errors++; $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl, 4'b0010); end
    n_checks++; if (bus.hrdata_o !== 32'h0) begin n_errors++; $display("[TB] FAIL reset_hrdata: got %h expected %h", bus.hrdata_o, 32'h0); end
    n_checks++; if (bus.paddr_o !== 32'h0) begin n_errors++; $display("[TB] FAIL reset_paddr: got %h expected %h", bus.paddr_o, 32'h0); end
    n_checks++; if (bus.pwrite_o !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_pwrite: got %b expected %b", bus.pwrite_o, 1'b0); end
    hrst = 1'b0;
    @(negedge hclk);
  endtask

  task automatic test_idle_busy();
    bus.hsel_i = 1'b1; bus.hready_i = 1'b1; bus.htrans_i = 2'b00; bus.haddr_i = 32'h90;
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b0010) begin n_errors++; $display("[TB] FAIL idle_ctrl: got %b expected %b", ctrl, 4'b0010); end
    bus.htrans_i = 2'b01;
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b0010) begin n_errors++; $display("[TB] FAIL busy_ctrl: got %b expected %b", ctrl, 4'b0010); end
    n_checks++; if (bus.paddr_o !== 32'h0) begin n_errors++; $display("[TB] FAIL busy_paddr: got %h expected %h", bus.paddr_o, 32'h0); end
    bus_idle();
  endtask

  task automatic test_read();
    bus.pready_i = 1'b1; bus.pslverr_i = 1'b0; bus.prdata_i = 32'hDEADBEEF;
    bus.hprot_i = 4'b0011; bus.hnonsec_i = 1'b0;
    apply_stimulus(32'h40, 1'b0, 3'd2);
    @(negedge hclk); bus_idle();
    n_checks++; if (ctrl !== 4'b1000) begin n_errors++; $display("[TB] FAIL read_setup_ctrl: got %b expected %b", ctrl, 4'b1000); end
    n_checks++; if (bus.paddr_o !== 32'h40) begin n_errors++; $display("[TB] FAIL read_paddr: got %h expected %h", bus.paddr_o, 32'h40); end
    n_checks++; if (bus.pprot_o !== 3'b001) begin n_errors++; $display("[TB] FAIL read_pprot: got %b expected %b", bus.pprot_o, 3'b001); end
    n_checks++; if (bus.pwrite_o !== 1'b0) begin n_errors++; $display("[TB] FAIL read_pwrite: got %b expected %b", bus.pwrite_o, 1'b0); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b1100) begin n_errors++; $display("[TB] FAIL read_access_ctrl: got %b expected %b", ctrl, 4'b1100); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b0010) begin n_errors++; $display("[TB] FAIL read_resp_ctrl: got %b expected %b", ctrl, 4'b0010); end
    n_checks++; if (bus.hrdata_o !== 32'hDEADBEEF) begin n_errors++; $display("[TB] FAIL read_hrdata: got %h expected %h", bus.hrdata_o, 32'hDEADBEEF); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b0010) begin n_errors++; $display("[TB] FAIL read_idle_ctrl: got %b expected %b", ctrl, 4'b0010); end
  endtask

  task automatic test_write();
    bus.pready_i = 1'b0; bus.prdata_i = 32'h55AA55AA;
    bus.hprot_i = 4'b0000; bus.hnonsec_i = 1'b1;
    apply_stimulus(32'h44, 1'b1, 3'd2);
    @(negedge hclk); bus_idle();
    bus.hwdata_i = 32'h12345678; bus.hwstrb_i = 4'b0011;
    n_checks++; if (ctrl !== 4'b0000) begin n_errors++; $display("[TB] FAIL write_wdata_ctrl: got %b expected %b", ctrl, 4'b0000); end
    @(negedge hclk);
    bus.hwdata_i = 32'hFFFFFFFF; bus.hwstrb_i = 4'b1111;
    n_checks++; if (ctrl !== 4'b1000) begin n_errors++; $display("[TB] FAIL write_setup_ctrl: got %b expected %b", ctrl, 4'b1000); end
    n_checks++; if (bus.pprot_o !== 3'b110) begin n_errors++; $display("[TB] FAIL write_pprot: got %b expected %b", bus.pprot_o, 3'b110); end
    n_checks++; if (bus.pwrite_o !== 1'b1) begin n_errors++; $display("[TB] FAIL write_pwrite: got %b expected %b", bus.pwrite_o, 1'b1); end
    for (int k = 0; k < 4; k++) begin
      @(negedge hclk);
      n_checks++; if (ctrl !== 4'b1100) begin n_errors++; $display("[TB] FAIL write_access%0d_ctrl: got %b expected %b", k, ctrl, 4'b1100); end
      n_checks++; if (bus.pwdata_o !== 32'h12345678) begin n_errors++; $display("[TB] FAIL write_access%0d_pwdata: got %h expected %h", k, bus.pwdata_o, 32'h12345678); end
      n_checks++; if (bus.pstrb_o !== 4'b0011) begin n_errors++; $display("[TB] FAIL write_access%0d_pstrb: got %b expected %b", k, bus.pstrb_o, 4'b0011); end
      n_checks++; if (bus.paddr_o !== 32'h44) begin n_errors++; $display("[TB] FAIL write_access%0d_paddr: got %h expected %h", k, bus.paddr_o, 32'h44); end
      bus.pready_i = (k == 3);
    end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b0010) begin n_errors++; $display("[TB] FAIL write_resp_ctrl: got %b expected %b", ctrl, 4'b0010); end
    n_checks++; if (bus.hrdata_o !== 32'hDEADBEEF) begin n_errors++; $display("[TB] FAIL write_hrdata_hold: got %h expected %h", bus.hrdata_o, 32'hDEADBEEF); end
    @(negedge hclk);
  endtask

  task automatic test_slverr();
    bus.pready_i = 1'b1; bus.pslverr_i = 1'b1; bus.prdata_i = 32'hCAFEF00D;
    apply_stimulus(32'h48, 1'b0, 3'd2);
    @(negedge hclk); bus_idle();
    n_checks++; if (ctrl !== 4'b1000) begin n_errors++; $display("[TB] FAIL slverr_setup_ctrl: got %b expected %b", ctrl, 4'b1000); end
    n_checks++; if (bus.pstrb_o !== 4'b0000) begin n_errors++; $display("[TB] FAIL slverr_read_pstrb: got %b expected %b", bus.pstrb_o, 4'b0000); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b1100) begin n_errors++; $display("[TB] FAIL slverr_access_ctrl: got %b expected %b", ctrl, 4'b1100); end
    @(negedge hclk);
    bus.pslverr_i = 1'b0;
    n_checks++; if (ctrl !== 4'b0001) begin n_errors++; $display("[TB] FAIL slverr_err1_ctrl: got %b expected %b", ctrl, 4'b0001); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b0011) begin n_errors++; $display("[TB] FAIL slverr_err2_ctrl: got %b expected %b", ctrl, 4'b0011); end
    n_checks++; if (bus.hrdata_o !== 32'hDEADBEEF) begin n_errors++; $display("[TB] FAIL slverr_hrdata_hold: got %h expected %h", bus.hrdata_o, 32'hDEADBEEF); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b0010) begin n_errors++; $display("[TB] FAIL slverr_idle_ctrl: got %b expected %b", ctrl, 4'b0010); end
  endtask

  task automatic test_timeout();
    bus.pready_i = 1'b0; bus.prdata_i = 32'hBAD0BAD0;
    apply_stimulus(32'h4C, 1'b0, 3'd2);
    @(negedge hclk); bus_idle();
    n_checks++; if (ctrl !== 4'b1000) begin n_errors++; $display("[TB] FAIL tmo_setup_ctrl: got %b expected %b", ctrl, 4'b1000); end
    for (int k = 0; k < 4; k++) begin
      @(negedge hclk);
      n_checks++; if (ctrl !== 4'b1100) begin n_errors++; $display("[TB] FAIL tmo_access%0d_ctrl: got %b expected %b", k, ctrl, 4'b1100); end
    end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b0001) begin n_errors++; $display("[TB] FAIL tmo_err1_ctrl: got %b expected %b", ctrl, 4'b0001); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b0011) begin n_errors++; $display("[TB] FAIL tmo_err2_ctrl: got %b expected %b", ctrl, 4'b0011); end
    n_checks++; if (bus.hrdata_o !== 32'hDEADBEEF) begin n_errors++; $display("[TB] FAIL tmo_hrdata_hold: got %h expected %h", bus.hrdata_o, 32'hDEADBEEF); end
    // Follow-up read accepted directly in ERR2.
    bus.pready_i = 1'b1; bus.prdata_i = 32'h600DF00D;
    apply_stimulus(32'h50, 1'b0, 3'd2);
    @(negedge hclk); bus_idle();
    n_checks++; if (ctrl !== 4'b1000) begin n_errors++; $display("[TB] FAIL tmo_next_setup_ctrl: got %b expected %b", ctrl, 4'b1000); end
    n_checks++; if (bus.paddr_o !== 32'h50) begin n_errors++; $display("[TB] FAIL tmo_next_paddr: got %h expected %h", bus.paddr_o, 32'h50); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b1100) begin n_errors++; $display("[TB] FAIL tmo_next_access_ctrl: got %b expected %b", ctrl, 4'b1100); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b0010) begin n_errors++; $display("[TB] FAIL tmo_next_resp_ctrl: got %b expected %b", ctrl, 4'b0010); end
    n_checks++; if (bus.hrdata_o !== 32'h600DF00D) begin n_errors++; $display("[TB] FAIL tmo_next_hrdata: got %h expected %h", bus.hrdata_o, 32'h600DF00D); end
    @(negedge hclk);
  endtask

  task automatic test_size_err();
    apply_stimulus(32'h60, 1'b0, 3'b011);
    @(negedge hclk); bus_idle();
    n_checks++; if (ctrl !== 4'b0001) begin n_errors++; $display("[TB] FAIL size_err1_ctrl: got %b expected %b", ctrl, 4'b0001); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b0011) begin n_errors++; $display("[TB] FAIL size_err2_ctrl: got %b expected %b", ctrl, 4'b0011); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b0010) begin n_errors++; $display("[TB] FAIL size_idle_ctrl: got %b expected %b", ctrl, 4'b0010); end
  endtask

  task automatic test_back_to_back();
    bus.pready_i = 1'b1; bus.prdata_i = 32'h11112222;
    apply_stimulus(32'h70, 1'b0, 3'd2);
    @(negedge hclk); bus_idle();
    n_checks++; if (ctrl !== 4'b1000) begin n_errors++; $display("[TB] FAIL b2b_rd_setup_ctrl: got %b expected %b", ctrl, 4'b1000); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b1100) begin n_errors++; $display("[TB] FAIL b2b_rd_access_ctrl: got %b expected %b", ctrl, 4'b1100); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b0010) begin n_errors++; $display("[TB] FAIL b2b_rd_resp_ctrl: got %b expected %b", ctrl, 4'b0010); end
    n_checks++; if (bus.hrdata_o !== 32'h11112222) begin n_errors++; $display("[TB] FAIL b2b_rd_hrdata: got %h expected %h", bus.hrdata_o, 32'h11112222); end
    apply_stimulus(32'h74, 1'b1, 3'd2);
    @(negedge hclk); bus_idle();
    bus.hwdata_i = 32'hA5A5A5A5; bus.hwstrb_i = 4'b1111;
    n_checks++; if (ctrl !== 4'b0000) begin n_errors++; $display("[TB] FAIL b2b_wr_wdata_ctrl: got %b expected %b", ctrl, 4'b0000); end
    n_checks++; if (bus.paddr_o !== 32'h74) begin n_errors++; $display("[TB] FAIL b2b_wr_paddr: got %h expected %h", bus.paddr_o, 32'h74); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b1000) begin n_errors++; $display("[TB] FAIL b2b_wr_setup_ctrl: got %b expected %b", ctrl, 4'b1000); end
    n_checks++; if (bus.pwdata_o !== 32'hA5A5A5A5) begin n_errors++; $display("[TB] FAIL b2b_wr_pwdata: got %h expected %h", bus.pwdata_o, 32'hA5A5A5A5); end
    n_checks++; if (bus.pstrb_o !== 4'b1111) begin n_errors++; $display("[TB] FAIL b2b_wr_pstrb: got %b expected %b", bus.pstrb_o, 4'b1111); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b1100) begin n_errors++; $display("[TB] FAIL b2b_wr_access_ctrl: got %b expected %b", ctrl, 4'b1100); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b0010) begin n_errors++; $display("[TB] FAIL b2b_wr_resp_ctrl: got %b expected %b", ctrl, 4'b0010); end
    n_checks++; if (bus.hrdata_o !== 32'h11112222) begin n_errors++; $display("[TB] FAIL b2b_wr_hrdata_hold: got %h expected %h", bus.hrdata_o, 32'h11112222); end
    @(negedge hclk);
  endtask

  task automatic test_reset_mid();
    bus.pready_i = 1'b0;
    apply_stimulus(32'h80, 1'b0, 3'd2);
    @(negedge hclk); bus_idle();
    n_checks++; if (ctrl !== 4'b1000) begin n_errors++; $display("[TB] FAIL rstmid_setup_ctrl: got %b expected %b", ctrl, 4'b1000); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b1100) begin n_errors++; $display("[TB] FAIL rstmid_access_ctrl: got %b expected %b", ctrl, 4'b1100); end
    hrst = 1'b1;
    @(negedge hclk);
    hrst = 1'b0;
    n_checks++; if (ctrl !== 4'b0010) begin n_errors++; $display("[TB] FAIL rstmid_ctrl: got %b expected %b", ctrl, 4'b0010); end
    n_checks++; if (bus.paddr_o !== 32'h0) begin n_errors++; $display("[TB] FAIL rstmid_paddr: got %h expected %h", bus.paddr_o, 32'h0); end
    n_checks++; if (bus.hrdata_o !== 32'h0) begin n_errors++; $display("[TB] FAIL rstmid_hrdata: got %h expected %h", bus.hrdata_o, 32'h0); end
    @(negedge hclk);
    n_checks++; if (ctrl !== 4'b0010) begin n_errors++; $display("[TB] FAIL rstmid_after_ctrl: got %b expected %b", ctrl, 4'b0010); end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    hrst          = 1'b1;
    bus.haddr_i   = '0;
    bus.hsize_i   = 3'd2;
    bus.hprot_i   = '0;
    bus.hnonsec_i = 1'b0;
    bus.htrans_i  = 2'b00;
    bus.hwrite_i  = 1'b0;
    bus.hwdata_i  = '0;
    bus.hwstrb_i  = '0;
    bus.hsel_i    = 1'b0;
    bus.hready_i  = 1'b1;
    bus.prdata_i  = '0;
    bus.pready_i  = 1'b0;
    bus.pslverr_i = 1'b0;

    test_reset();
    test_idle_busy();
    test_read();
    test_write();
    test_slverr();
    test_timeout();
    test_size_err();
    test_back_to_back();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge.md
Name: ahb_apb_bridge

Overview:
AHB-Lite slave to APB3/APB4 master bridge. It sits directly downstream of the AHB skid/register slice and consumes that slice's registered AHB request. Each AHB transfer is converted into one APB SETUP/ACCESS sequence, stalling the AHB data phase through hreadyout_o until the APB completer responds. The block also provides the two-cycle AHB ERROR response for PSLVERR, unsupported sizes and the optional access timeout.

Parameters:
ADDR_WIDTH, 32, AHB/APB address width
DATA_WIDTH, 32, data width; must be 8, 16, 32 or 64
HPROT_WIDTH, 4, AHB HPROT width (≥2)
TIMEOUT_CYCLES, 0, maximum ACCESS cycles without pready_i before an error is returned; 0 disables the timeout
STRB_WIDTH (local), DATA_WIDTH/8

Ports:
hclk_i  in  1  clock, all logic on rising edge
hrst_i  in  1  synchronous, active-high reset
haddr_i  in  ADDR_WIDTH  AHB address
hsize_i  in  3  AHB transfer size
hprot_i  in  HPROT_WIDTH  AHB protection
hnonsec_i  in  1  AHB non-secure
htrans_i  in  2  AHB transfer type
hwrite_i  in  1  AHB direction
hwdata_i  in  DATA_WIDTH  AHB write data (data phase)
hwstrb_i  in  STRB_WIDTH  AHB write strobes (data phase)
hsel_i  in  1  slave select
hready_i  in  1  global AHB HREADY
hrdata_o  out  DATA_WIDTH  read data
hreadyout_o  out  1  slave ready
hresp_o  out  1  0 OKAY, 1 ERROR
paddr_o  out  ADDR_WIDTH  APB address
pprot_o  out  3  APB protection
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
pwdata_o  out  DATA_WIDTH  APB write data
pstrb_o  out  STRB_WIDTH  APB strobes; all zero for reads
prdata_i  in  DATA_WIDTH  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB slave error

Behaviour:
- Clock and reset: one clock, hclk_i. hrst_i is a synchronous, active-high reset.
- Reset values: state IDLE; psel_o, penable_o, pwrite_o, hresp_o = 0; hreadyout_o = 1; all data/address registers = 0. Reset asserted mid-transfer drops psel_o/penable_o on the next edge with no completion to AHB.
- Accept condition: accept = hsel_i & hready_i & htrans_i[1] (NONSEQ or SEQ). IDLE and BUSY are ignored and produce an OKAY zero-wait response.
  - Accept is honoured only in IDLE, RESP and ERR2.
  - On accept, register haddr_i, hwrite_i and pprot.
  - pprot = {~hprot_i[0], hnonsec_i, hprot_i[1]}.
- Size check: size_bad = hsize_i > log2(STRB_WIDTH).
- States (all outputs registered):
  - IDLE: hreadyout_o=1. Accept → ERR1 if size_bad, else WDATA if write, else SETUP.
  - WDATA: hreadyout_o=0. Capture hwdata_i→pwdata_o and hwstrb_i→pstrb_o. → SETUP.
  - SETUP: psel_o=1, penable_o=0, hreadyout_o=0. → ACCESS.
  - ACCESS: psel_o=1, penable_o=1, hreadyout_o=0. Exits depend on pready_i and the timeout:
    - pready_i & ~pslverr_i: capture prdata_i (reads only) → RESP.
    - pready_i & pslverr_i: → ERR1.
    - Timeout count reaches TIMEOUT_CYCLES (≠0) without pready_i: → ERR1, with psel_o/penable_o dropped.
  - RESP: psel_o=0, penable_o=0, hreadyout_o=1, hresp_o=0, hrdata_o valid. Accept → as from IDLE; else → IDLE.
  - ERR1: hreadyout_o=0, hresp_o=1, psel_o=0. → ERR2.
  - ERR2: hreadyout_o=1, hresp_o=1. Accept → as from IDLE; else → IDLE.
- APB stability: paddr_o, pwrite_o, pwdata_o, pstrb_o and pprot_o are stable from SETUP through the final ACCESS cycle.
- hrdata_o hold rule: hrdata_o holds its last captured value. It is updated only on a successful read completion.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1). Cleared on entering ACCESS, increments each ACCESS cycle with pready_i=0. Fully removed when TIMEOUT_CYCLES=0.
- Latency (pready_i=1 on first ACCESS cycle):
  - Read: address cycle T, SETUP T+1, ACCESS T+2, RESP T+3 (2 wait states).
  - Write: WDATA T+1, SETUP T+2, ACCESS T+3, RESP T+4 (3 wait states).
- Back-to-back: a transfer accepted in RESP/ERR2 starts its SETUP/WDATA on the next cycle; there are no idle APB cycles beyond protocol requirements.
- No buffering: there is no request queue. hreadyout_o=0 guarantees that no second address phase completes while busy.

Test Plan:
- Read, addr 0x40, pready_i=1, prdata_i=0xDEADBEEF → psel_o at T+1, penable_o at T+2; T+3 hreadyout_o=1, hrdata_o=0xDEADBEEF, hresp_o=0.
- Write, addr 0x44, hwdata_i=0x12345678, hwstrb_i=4'b0011, pready_i low 3 cycles → pwdata_o/pstrb_o/paddr_o stable for all 4 ACCESS cycles; hreadyout_o low until RESP.
- Read with pslverr_i=1 → ERR1 (hreadyout_o=0, hresp_o=1) then ERR2 (hreadyout_o=1, hresp_o=1); hrdata_o unchanged.
- TIMEOUT_CYCLES=4, pready_i stuck 0 → psel_o drops after 4 ACCESS cycles, two-cycle ERROR follows; a subsequent read succeeds.
- hsize_i=3'b011 with DATA_WIDTH=32 → ERROR response, psel_o never asserted. Back-to-back NONSEQ read then write accepted in RESP → write WDATA starts the next cycle.
- Assert hrst_i during ACCESS → next edge psel_o=0, penable_o=0, hreadyout_o=1, hresp_o=0, state IDLE.
